// File: rtl/single_port_ram_arbiter.sv
// single_port_ram_arbiter
//
// Shares one single-port synchronous RAM (byte write enables, 1-cycle read
// latency) between port 0 (CPU data bus) and port 1 (debug/DMA loader).
// At most one access is issued per cycle; the winner sees a same-cycle ack
// and, for reads, a registered rvalid one cycle later. A requester that is
// granted with its lock input high keeps exclusive ownership until it makes
// a granted access with lock low.
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN defined   -> IDLE ties alternate using last_grant
//   SRAM_ARB_ROUND_ROBIN_EN undefined -> port 0 always wins IDLE ties
// Lock behaviour is the same in both builds.

module single_port_ram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req_0,
    input  logic                      lock_0,
    input  logic [ADDR_WIDTH-1:0]     addr_0,
    input  logic [DATA_WIDTH-1:0]     wdata_0,
    input  logic [DATA_WIDTH/8-1:0]   we_0,
    output logic                      ack_0,
    output logic                      rvalid_0,

    input  logic                      req_1,
    input  logic                      lock_1,
    input  logic [ADDR_WIDTH-1:0]     addr_1,
    input  logic [DATA_WIDTH-1:0]     wdata_1,
    input  logic [DATA_WIDTH/8-1:0]   we_1,
    output logic                      ack_1,
    output logic                      rvalid_1,

    output logic [DATA_WIDTH-1:0]     rdata,

    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_din,
    output logic [DATA_WIDTH/8-1:0]   ram_write_en,
    input  logic [DATA_WIDTH-1:0]     ram_dout
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Ownership states: IDLE arbitrates, OWNi admits only requester i.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_grant;     // 0: port 0 granted last, 1: port 1 granted last
    logic       tie_to_1;       // IDLE tie goes to port 1 when set
    logic       grant_0;
    logic       grant_1;
    logic       read_0;
    logic       read_1;

    // Tie-break decision for the IDLE state.
    always_comb begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        // The port that did not win last time takes the tie.
        tie_to_1 = ~last_grant;
`else
        // Fixed priority: port 0 always takes the tie; last_grant is tracked
        // but has no say in the decision.
        tie_to_1 = 1'b0 & last_grant;
`endif
    end

    // Grant selection and ownership next-state.
    always_comb begin
        grant_0    = 1'b0;
        grant_1    = 1'b0;
        state_next = state;

        // Reset masks every grant so the RAM sees no access while it is held.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (req_0 && req_1) begin
                        grant_0 = ~tie_to_1;
                        grant_1 = tie_to_1;
                    end else begin
                        grant_0 = req_0;
                        grant_1 = req_1;
                    end
                end
                OWN0:    grant_0 = req_0;
                OWN1:    grant_1 = req_1;
                default: ;
            endcase
        end

        // A granted access decides whether ownership is taken, kept or dropped;
        // without a grant the current ownership persists.
        if (grant_0) begin
            state_next = lock_0 ? OWN0 : IDLE;
        end else if (grant_1) begin
            state_next = lock_1 ? OWN1 : IDLE;
        end else if (state != OWN0 && state != OWN1) begin
            state_next = IDLE;
        end
    end

    assign ack_0  = grant_0;
    assign ack_1  = grant_1;
    assign read_0 = grant_0 && (we_0 == '0);
    assign read_1 = grant_1 && (we_1 == '0);

    // RAM command mux; all-zero when nothing is granted.
    always_comb begin
        ram_addr     = '0;
        ram_din      = '0;
        ram_write_en = '0;
        if (grant_0) begin
            ram_addr     = addr_0;
            ram_din      = wdata_0;
            ram_write_en = we_0;
        end else if (grant_1) begin
            ram_addr     = addr_1;
            ram_din      = wdata_1;
            ram_write_en = we_1;
        end
    end

    // Read data comes straight from the macro; rvalid qualifies it.
    assign rdata = ram_dout;

    // Ownership state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remember the most recent winner; resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant_0) begin
            last_grant <= 1'b0;
        end else if (grant_1) begin
            last_grant <= 1'b1;
        end
    end

    // Read-valid strobes follow a read grant by one cycle, matching RAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
        end else begin
            rvalid_0 <= read_0;
            rvalid_1 <= read_1;
        end
    end

    // Byte enables are passed through untouched, so width must divide evenly.
    logic unused_be_width;
    assign unused_be_width = (BE_WIDTH * 8 == DATA_WIDTH);

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Testbench for single_port_ram_arbiter: table-driven single-cycle vectors
// against a behavioural 1-cycle-latency byte-enable RAM, plus a hand-written
// reset-during-operation sequence. Honours SRAM_ARB_ROUND_ROBIN_EN for the
// contention expectations.

module tb_single_port_ram_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int BW = DW / 8;

    logic          clk;
    logic          reset;
    logic          req_0, req_1, lock_0, lock_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic [BW-1:0] we_0, we_1;
    logic          ack_0, ack_1, rvalid_0, rvalid_1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [BW-1:0] ram_write_en;
    logic [DW-1:0] ram_dout;

    int checks = 0;
    int errors = 0;

    single_port_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0), .we_0(we_0),
        .ack_0(ack_0), .rvalid_0(rvalid_0),
        .req_1(req_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1), .we_1(we_1),
        .ack_1(ack_1), .rvalid_1(rvalid_1),
        .rdata(rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_write_en(ram_write_en),
        .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with byte enables and 1-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        mem[14'h0123] = 16'hBEEF;
        mem[14'h0010] = 16'h1234;
    end
    always @(posedge clk) begin
        for (int b = 0; b < BW; b++)
            if (ram_write_en[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic          rst;
        logic          req0, req1, lock0, lock1;
        logic [AW-1:0] addr0, addr1;
        logic [DW-1:0] wd0, wd1;
        logic [BW-1:0] we0, we1;
        logic          ack0, ack1, rv0, rv1;
        logic [BW-1:0] rwe;
        logic [AW-1:0] raddr;
        logic [DW-1:0] rdin;
        logic [DW-1:0] rd;
        logic          chk_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst, input logic req0, input logic req1, input logic lock0, input logic lock1,
        input logic [AW-1:0] addr0, input logic [AW-1:0] addr1,
        input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
        input logic [BW-1:0] we0, input logic [BW-1:0] we1,
        input logic ack0, input logic ack1, input logic rv0, input logic rv1,
        input logic [BW-1:0] rwe, input logic [AW-1:0] raddr, input logic [DW-1:0] rdin,
        input logic [DW-1:0] rd, input logic chk_rd);
        vec_t r;
        r.rst = rst; r.req0 = req0; r.req1 = req1; r.lock0 = lock0; r.lock1 = lock1;
        r.addr0 = addr0; r.addr1 = addr1; r.wd0 = wd0; r.wd1 = wd1; r.we0 = we0; r.we1 = we1;
        r.ack0 = ack0; r.ack1 = ack1; r.rv0 = rv0; r.rv1 = rv1;
        r.rwe = rwe; r.raddr = raddr; r.rdin = rdin; r.rd = rd; r.chk_rd = chk_rd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset   = t.rst;
        req_0   = t.req0;  req_1   = t.req1;
        lock_0  = t.lock0; lock_1  = t.lock1;
        addr_0  = t.addr0; addr_1  = t.addr1;
        wdata_0 = t.wd0;   wdata_1 = t.wd1;
        we_0    = t.we0;   we_1    = t.we1;
    endtask

    task automatic idle_inputs();
        req_0 = 1'b0; req_1 = 1'b0; lock_0 = 1'b0; lock_1 = 1'b0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0; we_0 = '0; we_1 = '0;
    endtask

    localparam logic [AW-1:0] A0   = 14'h0000;
    localparam logic [AW-1:0] A10  = 14'h0010;
    localparam logic [AW-1:0] A123 = 14'h0123;
    localparam logic [AW-1:0] A200 = 14'h0200;
    localparam logic [AW-1:0] A300 = 14'h0300;
    localparam logic [DW-1:0] Z    = 16'h0000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();

        // rst req0 req1 lk0 lk1 addr0 addr1 wd0 wd1 we0 we1 | ack0 ack1 rv0 rv1 rwe raddr rdin rdata chk
        // Reset holds off acks even with both ports requesting.
        vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, A0, Z, Z, 1'b0));
        vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A0, A0, Z, Z, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, A0, Z, Z, 1'b0));
        // Single read from port 1.
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A0, A123, Z, Z, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, A123, Z, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0, A0, 16'h1111, Z, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, A0, Z, 16'hBEEF, 1'b1));
        // Contention: both ports read for 4 cycles, then port 0 drops.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, A10, Z, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, A123, Z, 16'h1234, 1'b1));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, A10, Z, 16'hBEEF, 1'b1));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, A123, Z, 16'h1234, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, A123, Z, 16'hBEEF, 1'b1));
`else
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, A10, Z, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, A10, Z, 16'h1234, 1'b1));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, A10, Z, 16'h1234, 1'b1));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, A10, Z, 16'h1234, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A10, A123, Z, Z, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, A123, Z, 16'h1234, 1'b1));
`endif
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0, A0, Z, Z, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, A0, Z, 16'hBEEF, 1'b1));
        // Low-byte write to 0x0010 then read it back.
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A10, A0, 16'hAA55, Z, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, A10, 16'hAA55, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A10, A0, 16'hAA55, Z, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, A10, 16'hAA55, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0, A0, Z, Z, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, A0, Z, 16'h1255, 1'b1));
        // Port 1 locks with a write, idles 2 cycles while port 0 waits, unlocks with a read.
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, A0, A200, Z, 16'h5A5A, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, A200, 16'h5A5A, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A10, A0, Z, Z, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, A0, Z, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A10, A0, Z, Z, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, A0, Z, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A10, A200, Z, Z, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, A200, Z, Z, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A10, A0, Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, A10, Z, 16'h5A5A, 1'b1));
        // Write right after a read leaves that read's rvalid intact.
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A0, A300, Z, 16'h0F0F, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, A300, 16'h0F0F, 16'h1255, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0, A0, Z, Z, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, A0, Z, Z, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d ack_0", i), 32'(ack_0), 32'(vecs[i].ack0));
            check($sformatf("v%0d ack_1", i), 32'(ack_1), 32'(vecs[i].ack1));
            check($sformatf("v%0d rvalid_0", i), 32'(rvalid_0), 32'(vecs[i].rv0));
            check($sformatf("v%0d rvalid_1", i), 32'(rvalid_1), 32'(vecs[i].rv1));
            check($sformatf("v%0d ram_write_en", i), 32'(ram_write_en), 32'(vecs[i].rwe));
            check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].raddr));
            check($sformatf("v%0d ram_din", i), 32'(ram_din), 32'(vecs[i].rdin));
            if (vecs[i].chk_rd)
                check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].rd));
        end

        // Reset while a port-0 read is pending and port 1 is taking a lock.
        @(posedge clk);
        #1;
        idle_inputs();
        req_0 = 1'b1; addr_0 = A123;
        @(negedge clk);
        check("rst_seq ack_0 read", 32'(ack_0), 32'd1);

        @(posedge clk);
        #1;
        idle_inputs();
        req_1 = 1'b1; lock_1 = 1'b1; addr_1 = A300; wdata_1 = 16'hFFFF; we_1 = 2'b11;
        @(negedge clk);
        check("rst_seq ack_1 lock", 32'(ack_1), 32'd1);
        check("rst_seq rvalid_0 before", 32'(rvalid_0), 32'd1);
        check("rst_seq rdata before", 32'(rdata), 32'hBEEF);
        #1;
        reset = 1'b1;
        #1;
        check("rst_seq rvalid_0 cleared", 32'(rvalid_0), 32'd0);
        check("rst_seq ack_1 masked", 32'(ack_1), 32'd0);
        check("rst_seq ram_write_en masked", 32'(ram_write_en), 32'd0);
        check("rst_seq ram_addr idle", 32'(ram_addr), 32'd0);

        @(posedge clk);
        #1;
        check("rst_seq ack_1 held", 32'(ack_1), 32'd0);
        check("rst_seq rvalid_1 held", 32'(rvalid_1), 32'd0);
        reset = 1'b0;
        idle_inputs();
        req_0 = 1'b1; addr_0 = A10;
        req_1 = 1'b1; addr_1 = A123;
        @(negedge clk);
        check("rst_seq first tie ack_0", 32'(ack_0), 32'd1);
        check("rst_seq first tie ack_1", 32'(ack_1), 32'd0);
        check("rst_seq first tie ram_addr", 32'(ram_addr), 32'(A10));

        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("rst_seq rvalid_0 after", 32'(rvalid_0), 32'd1);
        check("rst_seq rdata after", 32'(rdata), 32'h1255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
